// File: rtl/load_store_unit.sv
// Load/store unit: takes one memory op from the execute stage, checks
// funct3 and alignment, runs a req/gnt + rvalid handshake on the memory
// port, formats load data and reports completion or an error.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  funct3_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [4:0]  rd_i,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wb_valid_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic        store_q;
  logic [4:0]  rd_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        wb_we_q;
  logic [31:0] wb_data_q;

  logic        accept, f3_legal, misaligned, start_access, timeout_hit;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, shifted, load_result;

  // Request decode: acceptance, funct3 legality and alignment of the incoming op
  always_comb begin
    accept = req_valid_i & (state_q == IDLE) & (is_load_i ^ is_store_i);
    case (funct3_i)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = is_load_i;
      default:                f3_legal = 1'b0;
    endcase
    misaligned   = ((funct3_i[1:0] == 2'b01) & addr_i[0]) |
                   ((funct3_i[1:0] == 2'b10) & (|addr_i[1:0]));
    start_access = accept & f3_legal & ~misaligned;
    // Last allowed cycle in REQ/WAIT; a handshake on this cycle still wins
    timeout_hit  = cnt_q >= 8'(TIMEOUT - 1);
  end

  // Store lane steering: byte enables and replicated write data
  always_comb begin
    case (funct3_i[1:0])
      2'b00: begin
        be_new    = 4'b0001 << addr_i[1:0];
        wdata_new = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << addr_i[1:0];
        wdata_new = {2{wdata_i[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = wdata_i;
      end
    endcase
    if (is_load_i) be_new = 4'b1111;
  end

  // Load formatting: align the addressed byte/halfword to bit 0, then extend
  always_comb begin
    shifted = mem_rdata_i >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_result = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_result = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_result = {24'd0, shifted[7:0]};
      3'b101:  load_result = {16'd0, shifted[15:0]};
      default: load_result = shifted;
    endcase
  end

  // State, timeout counter and error pulse registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Next state, counter and error selection; illegal funct3 beats misalignment
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    err_code_d = 2'b00;
    case (state_q)
      IDLE: begin
        if (accept && !f3_legal) begin
          err_d      = 1'b1;
          err_code_d = 2'b10;
        end else if (accept && misaligned) begin
          err_d      = 1'b1;
          err_code_d = 2'b01;
        end else if (start_access) begin
          state_d = REQ;
          cnt_d   = 8'd0;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_gnt_i) begin
          state_d = WAIT;
        end else if (timeout_hit) begin
          state_d    = IDLE;
          err_d      = 1'b1;
          err_code_d = 2'b11;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_rvalid_i) begin
          state_d = RESP;
        end else if (timeout_hit) begin
          state_d    = IDLE;
          err_d      = 1'b1;
          err_code_d = 2'b11;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state and the captured request
  always_comb begin
    req_ready_o = (state_q == IDLE);
    mem_req_o   = (state_q == REQ);
    mem_we_o    = (state_q == REQ) & store_q;
    mem_addr_o  = {addr_q[31:2], 2'b00};
    mem_be_o    = be_q;
    mem_wdata_o = wdata_q;
    wb_valid_o  = (state_q == RESP);
    wb_we_o     = (state_q == RESP) & wb_we_q;
    wb_rd_o     = rd_q;
    wb_data_o   = wb_data_q;
    err_o       = err_q;
    err_code_o  = err_code_q;
  end

  // Request capture on acceptance and load result capture on the response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= 32'd0;
      funct3_q  <= 3'd0;
      store_q   <= 1'b0;
      rd_q      <= 5'd0;
      be_q      <= 4'd0;
      wdata_q   <= 32'd0;
      wb_we_q   <= 1'b0;
      wb_data_q <= 32'd0;
    end else if (accept) begin
      addr_q    <= addr_i;
      funct3_q  <= funct3_i;
      store_q   <= is_store_i;
      rd_q      <= rd_i;
      be_q      <= be_new;
      wdata_q   <= wdata_new;
      wb_we_q   <= is_load_i & (rd_i != 5'd0);
      wb_data_q <= 32'd0;
    end else if (state_q == WAIT && mem_rvalid_i && !store_q) begin
      wb_data_q <= load_result;
    end
  end

endmodule
